// File: rtl/alu_seq.sv
// alu_seq: sequential ALU feeding the accumulator's data_in/load.
// One operation per start pulse: IDLE -> EXEC (-> MUL) -> WB.
// The result and flags are registered on entry to WB. In WB, ac_load and
// done pulse for one cycle.
// Optional feature macro: ALU_MUL_EN.
//   Defined:   opcode 111 is an unsigned shift-add multiply taking WIDTH
//              extra cycles.
//   Undefined: opcode 111 passes b through in a single cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             ac_load,
  output logic             done,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_EXT = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

`ifdef ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] partial;
`endif

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state logic; start is only looked at in IDLE, so there is no queueing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
`ifdef ALU_MUL_EN
      S_EXEC: state_d = (op_q == OP_EXT) ? S_MUL : S_WB;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_WB;
`else
      S_EXEC: state_d = S_WB;
`endif
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    busy    = (state_q != S_IDLE);
    ac_load = (state_q == S_WB);
    done    = (state_q == S_WB);
  end

  // Datapath: latch operands on accept, compute in EXEC/MUL, commit on entry to WB
  always_comb begin
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_commit;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    alu_r      = '0;
    alu_c      = 1'b0;
    alu_commit = 1'b0;
`ifdef ALU_MUL_EN
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    partial    = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = opcode;
          a_d  = a;
          b_d  = b;
        end
      end
      S_EXEC: begin
        alu_commit = 1'b1;
        case (op_q)
          OP_ADD: {alu_c, alu_r} = {1'b0, a_q} + {1'b0, b_q};
          OP_SUB: begin
            alu_r = a_q - b_q;
            alu_c = (a_q < b_q);
          end
          OP_AND: alu_r = a_q & b_q;
          OP_OR:  alu_r = a_q | b_q;
          OP_XOR: alu_r = a_q ^ b_q;
          OP_SHL: {alu_c, alu_r} = {a_q, 1'b0};
          OP_SHR: begin
            alu_r = {1'b0, a_q[WIDTH-1:1]};
            alu_c = a_q[0];
          end
          default: begin
`ifdef ALU_MUL_EN
            // Multiply: start a fresh product, commit later from MUL
            alu_commit = 1'b0;
            prod_d     = '0;
            cnt_d      = '0;
`else
            // Pass-through of the memory operand
            alu_r = b_q;
`endif
          end
        endcase
        if (alu_commit) begin
          result_d = alu_r;
          carry_d  = alu_c;
          zero_d   = (alu_r == '0);
        end
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        // One multiplier bit per cycle, LSB first
        prod_d = prod_q + partial;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = prod_d[WIDTH-1:0];
          carry_d  = |prod_d[2*WIDTH-1:WIDTH];
          zero_d   = (prod_d[WIDTH-1:0] == '0);
        end
      end
`endif
      default: ;
    endcase
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// Cycle 0 is the cycle in which start is presented. The op then occupies
// EXEC in cycle 1 and WB in cycle 2, or cycle 2+WIDTH for a multiply.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam int EXT_LAT = 2 + W;
  localparam logic [W-1:0] EXT_RES = 8'h10;
  localparam logic EXT_C = 1'b1;
`else
  localparam int EXT_LAT = 2;
  localparam logic [W-1:0] EXT_RES = 8'h11;
  localparam logic EXT_C = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   opcode = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, ac_load, done, carry, zero;
  logic [W-1:0] result;

  int nerr = 0;
  int nchk = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .result(result), .ac_load(ac_load), .done(done),
    .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op (caller is just after a negedge) and follow it to completion
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er, input logic ec,
                        input logic ez, input int elat);
    int   nload = 0;
    int   first = 0;
    logic busy_bad = 1'b0;
    opcode = op; a = av; b = bv; start = 1'b1;
    for (int n = 1; n <= W + 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        // Operands change after acceptance and must be ignored
        start = 1'b0; a = ~av; b = av ^ bv ^ 8'h5A; opcode = ~op;
      end
      if (ac_load) begin
        nload++;
        if (first == 0) first = n;
      end
      if ((n <= elat) != busy) busy_bad = 1'b1;
      if (n == elat) begin
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_carry"},  32'(carry),  32'(ec));
        chk({tag, "_zero"},   32'(zero),   32'(ez));
        chk({tag, "_done"},   32'(done),   32'd1);
      end
      if (n == elat + 1) begin
        chk({tag, "_hold"}, 32'({ac_load, done, carry, zero, result}),
            32'({1'b0, 1'b0, ec, ez, er}));
      end
    end
    chk({tag, "_nload"}, 32'(nload), 32'd1);
    chk({tag, "_lat"},   32'(first), 32'(elat));
    chk({tag, "_busy"},  32'(busy_bad), 32'd0);
    $display("%s op=%0d a=0x%02h b=0x%02h -> result=0x%02h carry=%0b zero=%0b lat=%0d",
             tag, op, av, bv, result, carry, zero, first);
  endtask

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk("rst_state", 32'({busy, ac_load, done, carry, zero, result}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Reset during EXEC aborts the op with no ac_load
    opcode = 3'b000; a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    #1 chk("midrst_outs", 32'({busy, ac_load, done, carry, zero, result}), 32'd0);
    $display("midrst ADD a=0x05 b=0x03 aborted busy=%0b ac_load=%0b", busy, ac_load);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_idle", 32'({busy, ac_load, result}), 32'd0);
    end
    run_op("add_after_rst", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 2);

    run_op("add",   3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 2);
    run_op("sub_b", 3'b001, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 2);
    run_op("sub_z", 3'b001, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 2);
    run_op("shl",   3'b101, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 2);
    run_op("shr",   3'b110, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 2);
    run_op("xor",   3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 2);
    run_op("or",    3'b011, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0, 2);
    run_op("ext",   3'b111, 8'h10, 8'h11, EXT_RES, EXT_C, 1'b0, EXT_LAT);

    // start held high: one op per 3 cycles, accepted only in IDLE
    opcode = 3'b010; a = 8'h0F; b = 8'h3C; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("b2b_load", 32'(ac_load), 32'((n % 3) == 2));
      chk("b2b_busy", 32'(busy),    32'((n % 3) != 0));
      if ((n % 3) == 2) begin
        chk("b2b_result", 32'(result), 32'h0C);
        $display("b2b AND a=0x0F b=0x3C cycle=%0d -> result=0x%02h ac_load=%0b", n, result, ac_load);
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_drain", 32'({busy, ac_load}), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
